// File: rtl/display_scan_driver_if.sv
// display_scan_driver_if
//   Groups the data/control inputs and the display drive outputs of
//   display_scan_driver. clk and reset_n stay plain module ports.
//   master : the digit source / bench (drives enable, load, digits_In,
//            dp_In, blank_Lz; observes the display drive)
//   slave  : display_scan_driver itself
interface display_scan_driver_if;
    logic        enable;
    logic        load;
    logic [15:0] digits_In;
    logic [3:0]  dp_In;
    logic        blank_Lz;
    logic [1:0]  anode_Sel;
    logic [6:0]  seg_Out;
    logic        dp_Out;
    logic        frame_Done;

    modport master (
        output enable, load, digits_In, dp_In, blank_Lz,
        input  anode_Sel, seg_Out, dp_Out, frame_Done
    );

    modport slave (
        input  enable, load, digits_In, dp_In, blank_Lz,
        output anode_Sel, seg_Out, dp_Out, frame_Done
    );
endinterface

// File: rtl/display_scan_driver.sv
// display_scan_driver
//   Four-digit 7-segment scan controller. Each digit slot is SLOT cycles:
//   BLANK_CYCLES dark cycles, then the decoded digit. New data is held in
//   a shadow register and only copied to the display register at a frame
//   start, so a frame never mixes old and new digits.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : enable/load/digits_In/dp_In/blank_Lz in,
//              anode_Sel/seg_Out/dp_Out (active-low)/frame_Done out
module display_scan_driver #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    display_scan_driver_if.slave bus
);
    localparam int unsigned SLOT = CLK_HZ / SCAN_HZ;
    localparam int unsigned CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SLOT_END  = CW'(SLOT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [1:0]    r_idx, w_idx_nx;
    logic [15:0]   r_shadow_dig, r_disp_dig, w_disp_dig_nx;
    logic [3:0]    r_shadow_dp, r_disp_dp, w_disp_dp_nx;
    logic          r_pend, w_pend_nx;
    logic          w_frame_start, w_wrap;
    logic [3:0]    w_lz, w_nib;
    logic [6:0]    r_seg, w_seg_nx;
    logic          r_dp, w_dp_nx;
    logic          r_done;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'd0:    f_decode = 7'b1000000;
            4'd1:    f_decode = 7'b1111001;
            4'd2:    f_decode = 7'b0100100;
            4'd3:    f_decode = 7'b0110000;
            4'd4:    f_decode = 7'b0011001;
            4'd5:    f_decode = 7'b0010010;
            4'd6:    f_decode = 7'b0000010;
            4'd7:    f_decode = 7'b1111000;
            4'd8:    f_decode = 7'b0000000;
            4'd9:    f_decode = 7'b0010000;
            default: f_decode = 7'b0111111;
        endcase
    endfunction

    // Scan sequencing; the slot counter runs across BLANK and SHOW.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_idx_nx      = r_idx;
        w_frame_start = 1'b0;
        w_wrap        = 1'b0;
        if (!bus.enable) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_idx_nx   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx    = ST_BLANK;
                    w_cnt_nx      = '0;
                    w_idx_nx      = '0;
                    w_frame_start = 1'b1;
                end
                ST_BLANK: begin
                    w_cnt_nx = r_cnt + CW'(1);
                    if (r_cnt == CNT_BLANK_END) w_state_nx = ST_SHOW;
                end
                ST_SHOW: begin
                    if (r_cnt == CNT_SLOT_END) begin
                        w_cnt_nx   = '0;
                        w_idx_nx   = r_idx + 2'd1;
                        w_state_nx = ST_BLANK;
                        if (r_idx == 2'd3) begin
                            w_frame_start = 1'b1;
                            w_wrap        = 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                end
            endcase
        end
    end

    // The frame-start copy takes the pre-load shadow; a coincident load
    // re-arms pending so it lands one frame later.
    always_comb begin
        w_disp_dig_nx = r_disp_dig;
        w_disp_dp_nx  = r_disp_dp;
        w_pend_nx     = r_pend;
        if (w_frame_start && r_pend) begin
            w_disp_dig_nx = r_shadow_dig;
            w_disp_dp_nx  = r_shadow_dp;
            w_pend_nx     = 1'b0;
        end
        if (bus.load) w_pend_nx = 1'b1;
    end

    // Outputs are computed from next-state values and registered, so they
    // line up with the state they belong to without combinational glitches.
    always_comb begin
        w_lz[3] = (w_disp_dig_nx[15:12] == 4'd0);
        w_lz[2] = w_lz[3] && (w_disp_dig_nx[11:8] == 4'd0);
        w_lz[1] = w_lz[2] && (w_disp_dig_nx[7:4] == 4'd0);
        w_lz[0] = 1'b0;
        case (w_idx_nx)
            2'd0:    w_nib = w_disp_dig_nx[3:0];
            2'd1:    w_nib = w_disp_dig_nx[7:4];
            2'd2:    w_nib = w_disp_dig_nx[11:8];
            default: w_nib = w_disp_dig_nx[15:12];
        endcase
        w_seg_nx = 7'h7F;
        w_dp_nx  = 1'b1;
        if (w_state_nx == ST_SHOW) begin
            w_seg_nx = (bus.blank_Lz && w_lz[w_idx_nx]) ? 7'h7F : f_decode(w_nib);
            w_dp_nx  = ~w_disp_dp_nx[w_idx_nx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow_dig <= '0;
            r_shadow_dp  <= '0;
            r_disp_dig   <= '0;
            r_disp_dp    <= '0;
            r_pend       <= 1'b0;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_idx      <= w_idx_nx;
            r_disp_dig <= w_disp_dig_nx;
            r_disp_dp  <= w_disp_dp_nx;
            r_pend     <= w_pend_nx;
            r_seg      <= w_seg_nx;
            r_dp       <= w_dp_nx;
            r_done     <= w_wrap;
            if (bus.load) begin
                r_shadow_dig <= bus.digits_In;
                r_shadow_dp  <= bus.dp_In;
            end
        end
    end

    assign bus.anode_Sel  = r_idx;
    assign bus.seg_Out    = r_seg;
    assign bus.dp_Out     = r_dp;
    assign bus.frame_Done = r_done;
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver
//   Directed bench for display_scan_driver with SLOT=10, BLANK_CYCLES=2.
module tb_display_scan_driver;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    display_scan_driver_if bus ();

    display_scan_driver #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .BLANK_CYCLES(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Captured per-digit values from one frame, plus count of cycles that
    // broke slot shape (anode, dark cycles, steady lit value, frame_Done).
    logic [6:0] obs_seg [4];
    logic       obs_dp  [4];
    int         obs_bad;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        bus.digits_In = d;
        bus.dp_In     = p;
        bus.load      = 1'b1;
        tick();
        bus.load      = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (bus.frame_Done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Starts on a frame_Done cycle (slot 0, cycle 0); ends on the next one.
    task automatic capture_frame;
        int s;
        int p;
        obs_bad = 0;
        for (int j = 0; j < 40; j++) begin
            s = j / 10;
            p = j % 10;
            if (bus.anode_Sel !== 2'(s)) obs_bad++;
            if (bus.frame_Done !== (j == 0)) obs_bad++;
            if (p < 2) begin
                if (bus.seg_Out !== 7'h7F || bus.dp_Out !== 1'b1) obs_bad++;
            end else if (p == 2) begin
                obs_seg[s] = bus.seg_Out;
                obs_dp[s]  = bus.dp_Out;
            end else if (bus.seg_Out !== obs_seg[s] || bus.dp_Out !== obs_dp[s]) begin
                obs_bad++;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        int bad;
        reset_n       = 1'b0;
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.digits_In = '0;
        bus.dp_In     = '0;
        bus.blank_Lz  = 1'b0;
        #12;
        checks++;
        if (bus.anode_Sel !== 2'd0 || bus.seg_Out !== 7'h7F || bus.dp_Out !== 1'b1 || bus.frame_Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: anode=%0d seg=%h dp=%b done=%b, want 0 7f 1 0",
                     bus.anode_Sel, bus.seg_Out, bus.dp_Out, bus.frame_Done);
        end
        tick();
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.anode_Sel !== 2'd0 || bus.seg_Out !== 7'h7F || bus.dp_Out !== 1'b1 || bus.frame_Done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_after_reset: %0d cycles off reset values, want 0", bad);
        end
    endtask

    task automatic test_basic_scan;
        bit ok;
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_load(16'h1234, 4'b0100);
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.anode_Sel !== 2'd0 || bus.seg_Out !== 7'h7F || bus.frame_Done !== 1'b0) begin
            errors++;
            $display("FAIL enable_blank: anode=%0d seg=%h done=%b, want 0 7f 0",
                     bus.anode_Sel, bus.seg_Out, bus.frame_Done);
        end
        tick();
        checks++;
        if (bus.seg_Out !== 7'h7F) begin
            errors++;
            $display("FAIL enable_second_dark: seg=%h, want 7f", bus.seg_Out);
        end
        tick();
        checks++;
        if (bus.seg_Out !== 7'h19 || bus.dp_Out !== 1'b1) begin
            errors++;
            $display("FAIL enable_first_lit: seg=%h dp=%b, want 19 1", bus.seg_Out, bus.dp_Out);
        end
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_frame_timeout: no frame_Done within 60 cycles");
        end
        capture_frame();
        checks++;
        if (obs_bad !== 0) begin
            errors++;
            $display("FAIL basic_slot_shape: %0d bad cycles, want 0", obs_bad);
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_seg[d] !== exp_seg[d] || obs_dp[d] !== exp_dp[d]) begin
                errors++;
                $display("FAIL basic_digit%0d: seg=%h dp=%b, want %h %b",
                         d, obs_seg[d], obs_dp[d], exp_seg[d], exp_dp[d]);
            end
        end
        checks++;
        if (bus.frame_Done !== 1'b1) begin
            errors++;
            $display("FAIL frame_period: frame_Done=%b 40 cycles later, want 1", bus.frame_Done);
        end
    endtask

    task automatic test_no_tearing;
        bit ok;
        do_load(16'h1111, 4'b0000);
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tear_frame_timeout: no frame_Done within 60 cycles");
        end
        ticks(15);
        do_load(16'h8888, 4'b0000);
        ticks(9);
        checks++;
        if (bus.anode_Sel !== 2'd2 || bus.seg_Out !== 7'h79) begin
            errors++;
            $display("FAIL tear_digit2: anode=%0d seg=%h, want 2 79", bus.anode_Sel, bus.seg_Out);
        end
        ticks(10);
        checks++;
        if (bus.anode_Sel !== 2'd3 || bus.seg_Out !== 7'h79) begin
            errors++;
            $display("FAIL tear_digit3: anode=%0d seg=%h, want 3 79", bus.anode_Sel, bus.seg_Out);
        end
        ticks(5);
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_seg[d] !== 7'h00) begin
                errors++;
                $display("FAIL tear_new_digit%0d: seg=%h, want 00", d, obs_seg[d]);
            end
        end
        // Load on the edge where the index wraps: deferred one frame.
        ticks(39);
        do_load(16'h5555, 4'b0000);
        checks++;
        if (bus.frame_Done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_load_align: frame_Done=%b, want 1", bus.frame_Done);
        end
        capture_frame();
        checks++;
        if (obs_seg[0] !== 7'h00 || obs_seg[3] !== 7'h00) begin
            errors++;
            $display("FAIL wrap_load_deferred: seg0=%h seg3=%h, want 00 00", obs_seg[0], obs_seg[3]);
        end
        capture_frame();
        checks++;
        if (obs_seg[0] !== 7'h12 || obs_seg[3] !== 7'h12) begin
            errors++;
            $display("FAIL wrap_load_applied: seg0=%h seg3=%h, want 12 12", obs_seg[0], obs_seg[3]);
        end
    endtask

    task automatic test_leading_zero;
        bit ok;
        logic [6:0] exp_on  [4];
        logic [6:0] exp_off [4];
        exp_on  = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        exp_off = '{7'h40, 7'h12, 7'h40, 7'h40};
        bus.blank_Lz = 1'b1;
        do_load(16'h0050, 4'b1000);
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lz_frame_timeout: no frame_Done within 60 cycles");
        end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_seg[d] !== exp_on[d] || obs_dp[d] !== (d != 3)) begin
                errors++;
                $display("FAIL lz_on_digit%0d: seg=%h dp=%b, want %h %b",
                         d, obs_seg[d], obs_dp[d], exp_on[d], (d != 3));
            end
        end
        bus.blank_Lz = 1'b0;
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_seg[d] !== exp_off[d]) begin
                errors++;
                $display("FAIL lz_off_digit%0d: seg=%h, want %h", d, obs_seg[d], exp_off[d]);
            end
        end
    endtask

    task automatic test_invalid_bcd;
        bit ok;
        logic [6:0] exp_seg [4];
        exp_seg = '{7'h40, 7'h40, 7'h3F, 7'h3F};
        bus.blank_Lz = 1'b1;
        do_load(16'hFA00, 4'b0000);
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bcd_frame_timeout: no frame_Done within 60 cycles");
        end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_seg[d] !== exp_seg[d]) begin
                errors++;
                $display("FAIL bcd_digit%0d: seg=%h, want %h", d, obs_seg[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_abort;
        bit ok;
        ticks(25);
        checks++;
        if (bus.anode_Sel !== 2'd2 || bus.seg_Out !== 7'h3F) begin
            errors++;
            $display("FAIL abort_pre: anode=%0d seg=%h, want 2 3f", bus.anode_Sel, bus.seg_Out);
        end
        bus.enable = 1'b0;
        tick();
        checks++;
        if (bus.anode_Sel !== 2'd0 || bus.seg_Out !== 7'h7F || bus.dp_Out !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: anode=%0d seg=%h dp=%b, want 0 7f 1",
                     bus.anode_Sel, bus.seg_Out, bus.dp_Out);
        end
        ticks(5);
        bus.enable = 1'b1;
        ticks(23);
        checks++;
        if (bus.anode_Sel !== 2'd2 || bus.seg_Out !== 7'h3F) begin
            errors++;
            $display("FAIL abort_retained: anode=%0d seg=%h, want 2 3f", bus.anode_Sel, bus.seg_Out);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if (bus.anode_Sel !== 2'd0 || bus.seg_Out !== 7'h7F || bus.dp_Out !== 1'b1 || bus.frame_Done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: anode=%0d seg=%h dp=%b done=%b, want 0 7f 1 0",
                     bus.anode_Sel, bus.seg_Out, bus.dp_Out, bus.frame_Done);
        end
        ticks(2);
        reset_n = 1'b1;
        tick();
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL restart_timeout: no frame_Done within 60 cycles");
        end
        capture_frame();
        checks++;
        if (obs_seg[0] !== 7'h40 || obs_seg[1] !== 7'h7F || obs_seg[2] !== 7'h7F || obs_seg[3] !== 7'h7F) begin
            errors++;
            $display("FAIL restart_display_cleared: segs=%h %h %h %h, want 40 7f 7f 7f",
                     obs_seg[0], obs_seg[1], obs_seg[2], obs_seg[3]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic_scan();
        test_no_tearing();
        test_leading_zero();
        test_invalid_bcd();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Time-multiplexed scan controller for the four-digit 7-segment display. It generates the 2-bit digit index consumed by the anode decoder and the matching active-low segment and decimal-point drive. It inserts a blanking interval at each digit change to suppress ghosting and applies new display data only on frame boundaries, so a digit update never tears mid-frame. It sits between the clock/puzzle logic, which supplies BCD digits, and the anode decoder plus the board pins.

## Interface
- CLK_HZ, 100_000_000: system clock frequency.
- SCAN_HZ, 1000: digit slot rate. Slot length is SLOT = CLK_HZ/SCAN_HZ cycles. Requires SLOT ≥ 4.
- BLANK_CYCLES, 64: segments-off cycles at the start of every slot. Requires 1 ≤ BLANK_CYCLES < SLOT.

- clk  in  1  system clock; everything is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning enable. Low forces the IDLE state.
- load  in  1  one-cycle strobe that captures digits_In and dp_In into the shadow register.
- digits_In  in  16  four BCD nibbles; digit 0 is [3:0] and digit 3 is [15:12].
- dp_In  in  4  decimal point per digit, active-high; bit i belongs to digit i.
- blank_Lz  in  1  leading-zero blanking enable.
- anode_Sel  out  2  index of the currently scanned digit, fed to the anode decoder.
- seg_Out  out  7  {g,f,e,d,c,b,a}, active-low.
- dp_Out  out  1  decimal point, active-low.
- frame_Done  out  1  one-cycle pulse marking the end of each frame.

## Operation
- Registers:
  - shadow: 16+4 bits, written on load.
  - display: 16+4 bits, copied from shadow at each frame start.
  - pending flag: set by load, cleared when display takes the copy.
  - slot counter: 0..SLOT-1.
  - 2-bit digit index, which drives anode_Sel.
- FSM states are IDLE, BLANK and SHOW.
  - IDLE: seg_Out=7'h7F, dp_Out=1, anode_Sel=0, slot counter=0. When enable=1, go to BLANK at digit 0; this counts as a frame start.
  - BLANK: seg_Out=7'h7F, dp_Out=1. When the slot counter reaches BLANK_CYCLES-1, go to SHOW.
  - SHOW: drive the decoded digit. When the slot counter reaches SLOT-1, advance the digit index (3 wraps to 0) and go to BLANK.
  - When the index wraps 3→0, assert frame_Done for that cycle; that cycle is a frame start.
  - enable=0 in any state returns to IDLE on the next edge. The display register is retained.
- Frame start: if pending=1, copy shadow into display and clear pending.
  - The copy uses the shadow value before any load occurring in the same cycle.
  - A load coincident with a frame start sets pending and is applied at the following frame start.
- Segment decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles 10-15 display a dash: 0111111.
- Leading-zero blanking, when blank_Lz=1:
  - Digit i (i=3,2,1) is blanked (7'h7F) if it and every higher digit equal 0.
  - Digit 0 is never blanked.
  - A blanked digit's dp still follows dp_In.
- dp_Out = ~display dp[index] during SHOW, and 1 otherwise.

## Timing
- Reset values:
  - Outputs: anode_Sel=0, seg_Out=7'h7F, dp_Out=1, frame_Done=0.
  - Internal: state IDLE, display=0, shadow=0, pending=0, slot counter=0.
- All outputs are registered and glitch-free. anode_Sel changes only on the cycle BLANK is entered, so the anode switches while the segments are dark.
- Slot layout: cycles 0..BLANK_CYCLES-1 are dark; cycles BLANK_CYCLES..SLOT-1 show the digit. A frame is 4·SLOT cycles.
- Enable latency: enable rising at edge k gives BLANK with anode_Sel=0 after edge k+1. First segments lit after edge k+1+BLANK_CYCLES.
- Load-to-display latency: at most 4·SLOT cycles. With enable=0 the load stays pending until the first frame start after enable.
- Reset asserted mid-slot: all outputs take their reset values immediately, asynchronously. Scanning restarts from IDLE after release.
- The slot counter saturates nowhere; it always wraps at SLOT-1.

## Test plan
Test parameters: CLK_HZ=1000, SCAN_HZ=100 (SLOT=10), BLANK_CYCLES=2.

- Reset/idle: hold reset_n=0, then release with enable=0 → anode_Sel=0, seg_Out=7'h7F, dp_Out=1, frame_Done=0 indefinitely.
- Basic scan: load digits_In=16'h1234, dp_In=4'b0100, enable=1 → from the next frame:
  - digit 0 shows 0011001 (4), digit 1 shows 0110000 (3), digit 2 shows 0100100 (2) with dp_Out=0, digit 3 shows 1111001 (1).
  - Each slot has 2 dark cycles followed by 8 lit cycles.
  - frame_Done pulses every 40 cycles.
- Leading zeros: load 16'h0050 with blank_Lz=1 → digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0. With blank_Lz=0, all four digits are shown.
- No tearing: load 16'h8888 mid-frame while 16'h1111 is displayed → the remainder of the current frame shows 1; the next frame shows 8 on all digits. A load on the frame_Done cycle takes effect one frame later.
- Invalid BCD: load 16'hFA00 → digits 3 and 2 show dash 0111111.
- Enable/reset abort: drop enable during SHOW of digit 2 → the next edge gives IDLE, seg 7'h7F and anode_Sel=0. Assert reset_n=0 mid-slot → outputs take reset values with no clock edge.
